// File: rtl/store_buffer.sv
// Store buffer: packs MEM-stage sb/sh/sw into word beats, head visible the cycle after push; st_ready_o drops only when full.
// Optional STORE_BUF_FWD_EN: exact word-address load-hit compare instead of the conservative "any pending store" stall.
module store_buffer #(
  parameter int Depth = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        st_valid_i,
  output logic        st_ready_o,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_data_i,
  input  logic [1:0]  st_size_i,
  output logic        misalign_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  output logic        empty_o,
  input  logic [31:0] ld_addr_i,
  output logic        ld_hit_o
);
  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(Depth);

  logic [31:0]   r_addr  [Depth];
  logic [31:0]   r_wdata [Depth];
  logic [3:0]    r_be    [Depth];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_misalign;

  logic          w_misalign;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic          w_ld_hit;

  always_comb begin
    w_wdata    = st_data_i;
    w_be       = 4'b0000;
    w_misalign = 1'b0;
    case (st_size_i)
      2'b00: begin
        w_wdata = {4{st_data_i[7:0]}};
        w_be    = 4'b0001 << st_addr_i[1:0];
      end
      2'b01: begin
        w_wdata    = {2{st_data_i[15:0]}};
        w_be       = 4'b0011 << st_addr_i[1:0];
        w_misalign = st_addr_i[0];
      end
      2'b10: begin
        w_be       = 4'b1111;
        w_misalign = |st_addr_i[1:0];
      end
      default: w_misalign = 1'b1;
    endcase
  end

  // Ready depends on the registered count only, so a pop never frees a slot for a same-cycle push.
  assign st_ready_o  = (r_count != FULL);
  assign mem_valid_o = (r_count != '0);
  assign empty_o     = (r_count == '0);
  assign misalign_o  = r_misalign;

  assign w_push = st_valid_i & st_ready_o & ~w_misalign;
  assign w_pop  = mem_valid_o & mem_ready_i;

  assign mem_addr_o  = mem_valid_o ? r_addr[r_rd_ptr]  : 32'h0;
  assign mem_wdata_o = mem_valid_o ? r_wdata[r_rd_ptr] : 32'h0;
  assign mem_be_o    = mem_valid_o ? r_be[r_rd_ptr]    : 4'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= st_valid_i & st_ready_o & w_misalign;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) begin
      r_addr[r_wr_ptr]  <= {st_addr_i[31:2], 2'b00};
      r_wdata[r_wr_ptr] <= w_wdata;
      r_be[r_wr_ptr]    <= w_be;
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic w_unused_ld;
  assign w_unused_ld = ^ld_addr_i[1:0];

  // Only slots between the read pointer and read pointer + count hold live stores.
  always_comb begin
    w_ld_hit = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if ((CW'(i) < r_count) &&
          (r_addr[r_rd_ptr + PW'(i)] == {ld_addr_i[31:2], 2'b00}))
        w_ld_hit = 1'b1;
    end
  end
`else
  logic w_unused_ld;
  assign w_unused_ld = ^ld_addr_i;
  assign w_ld_hit    = ~empty_o;
`endif

  assign ld_hit_o = w_ld_hit;

endmodule

// File: tb/tb_store_buffer.sv
// Randomized + directed bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
  localparam int Depth = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [1:0]  st_size_i;
  logic        misalign_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        empty_o;
  logic [31:0] ld_addr_i;
  logic        ld_hit_o;

  always #5 clk_i = ~clk_i;

  store_buffer #(.Depth(Depth)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_size_i(st_size_i),
    .misalign_o(misalign_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .empty_o(empty_o), .ld_addr_i(ld_addr_i), .ld_hit_o(ld_hit_o)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  b;
  } beat_t;

  beat_t q[$];
  logic  exp_mis = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic misaligned(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic beat_t pack(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    beat_t b;
    int off = int'(a % 4);
    b.a = a - (a % 4);
    case (sz)
      2'd0: begin b.w = d[7:0] * 32'h01010101;  b.b = 4'(1 << off); end
      2'd1: begin b.w = d[15:0] * 32'h00010001; b.b = 4'(3 << off); end
      default: begin b.w = d; b.b = 4'hF; end
    endcase
    return b;
  endfunction

  function automatic logic exp_hit(input logic [31:0] la);
`ifdef STORE_BUF_FWD_EN
    foreach (q[i]) if (q[i].a == la - (la % 4)) return 1'b1;
    return 1'b0;
`else
    return q.size() != 0;
`endif
  endfunction

  // Drive one cycle of inputs, compare outputs with the model mid-cycle, then advance the model.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic mr, input logic r, input logic [31:0] la);
    st_valid_i = v; st_addr_i = a; st_data_i = d; st_size_i = sz;
    mem_ready_i = mr; rst_i = r; ld_addr_i = la;
    @(negedge clk_i);
    check("st_ready",  st_ready_o,  q.size() != Depth);
    check("mem_valid", mem_valid_o, q.size() != 0);
    check("empty",     empty_o,     q.size() == 0);
    check("misalign",  misalign_o,  exp_mis);
    check("ld_hit",    ld_hit_o,    exp_hit(la));
    check("mem_addr",  mem_addr_o,  q.size() != 0 ? q[0].a : 32'h0);
    check("mem_wdata", mem_wdata_o, q.size() != 0 ? q[0].w : 32'h0);
    check("mem_be",    mem_be_o,    q.size() != 0 ? q[0].b : 4'h0);
    if (r) begin
      q.delete();
      exp_mis = 1'b0;
    end else begin
      bit    can  = q.size() < Depth;
      bit    pop  = q.size() > 0 && mr;
      bit    bad  = misaligned(a, sz);
      beat_t nb   = pack(a, d, sz);
      exp_mis = v && can && bad;
      if (pop) void'(q.pop_front());
      if (v && can && !bad) q.push_back(nb);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    st_valid_i = 0; st_addr_i = 0; st_data_i = 0; st_size_i = 0;
    mem_ready_i = 0; ld_addr_i = 0; rst_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 0;

    step(0, 0, 0, 0, 1, 0, 0);
    check("rst_empty", empty_o, 1);
    check("rst_ready", st_ready_o, 1);

    step(1, 32'h1003, 32'h000000AB, 2'd0, 0, 0, 0);
    check("sb_addr", mem_addr_o, 32'h1000);
    check("sb_wdata", mem_wdata_o, 32'hABABABAB);
    check("sb_be", mem_be_o, 4'b1000);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 32'h2002, 32'h00001234, 2'd1, 0, 0, 0);
    check("sh_wdata", mem_wdata_o, 32'h12341234);
    check("sh_be", mem_be_o, 4'b1100);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 32'h3000, 32'hDEADBEEF, 2'd2, 0, 0, 0);
    check("sw_wdata", mem_wdata_o, 32'hDEADBEEF);
    check("sw_be", mem_be_o, 4'b1111);
    step(0, 0, 0, 0, 1, 0, 0);

    step(1, 32'h0001, 32'h1, 2'd1, 1, 0, 0);
    check("mis_h_pulse", misalign_o, 1);
    check("mis_h_empty", empty_o, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    check("mis_h_end", misalign_o, 0);
    step(1, 32'h0002, 32'h2, 2'd2, 1, 0, 0);
    check("mis_w_pulse", misalign_o, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 32'h0000, 32'h3, 2'd3, 1, 0, 0);
    check("mis_r_pulse", misalign_o, 1);
    step(0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 4; i++) step(1, 32'h100 + 4 * i, i, 2'd2, 0, 0, 0);
    check("full_ready", st_ready_o, 0);
    step(1, 32'h200, 32'h55, 2'd2, 0, 0, 0);
    step(1, 32'h200, 32'h55, 2'd2, 1, 0, 0);
    check("full_pop_ready", st_ready_o, 1);
    step(1, 32'h200, 32'h55, 2'd2, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 32'h500 + 4 * i, 32'hA0 + i, 2'd2, 1, 0, 0);
    repeat (8) step(0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 3; i++) step(1, 32'h600 + 4 * i, i, 2'd2, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    check("rst_mid_valid", mem_valid_o, 0);
    check("rst_mid_empty", empty_o, 1);
    repeat (2) step(0, 0, 0, 0, 1, 0, 0);

    step(1, 32'h4000, 32'h77, 2'd2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h4002);
    check("fwd_hit", ld_hit_o, 1);
    ld_addr_i = 32'h4004;
    #1;
`ifdef STORE_BUF_FWD_EN
    check("fwd_miss", ld_hit_o, 0);
`else
    check("fwd_miss", ld_hit_o, 1);
`endif
    repeat (2) step(0, 0, 0, 0, 1, 0, 0);

    for (int n = 0; n < 600; n++) begin
      logic [1:0] sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      step($urandom % 4 != 0, 32'h4000 + $urandom_range(0, 31), $urandom, sz,
           $urandom % 3 != 0, $urandom % 100 == 0, 32'h4000 + $urandom_range(0, 31));
    end
    repeat (6) step(0, 0, 0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Store-side companion to the load-path sign/zero extenders: narrows MEM-stage stores (byte/half/word) into word-aligned write beats with byte enables and queues them toward data memory. It sits between the pipeline MEM stage and the data-memory write port. It decouples store issue from memory acceptance with a small FIFO and a valid/ready handshake on both sides.

## Interface
Parameters:
- `Depth`, 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clk_i`  input  1  clock; all state updates on rising edge.
- `rst_i`  input  1  reset, synchronous, active-high.
- `st_valid_i`  input  1  MEM stage presents a store.
- `st_ready_o`  output  1  buffer can accept a store this cycle.
- `st_addr_i`  input  32  byte address of the store.
- `st_data_i`  input  32  store data, LSB-justified.
- `st_size_i`  input  2  00 byte, 01 half, 10 word, 11 reserved.
- `misalign_o`  output  1  one-cycle pulse: offered store rejected.
- `mem_valid_o`  output  1  head entry valid toward memory.
- `mem_ready_i`  input  1  memory accepts the beat.
- `mem_addr_o`  output  32  word address: `{addr[31:2], 2'b00}`.
- `mem_wdata_o`  output  32  lane-replicated write data.
- `mem_be_o`  output  4  byte enables.
- `empty_o`  output  1  no entries pending.
- `ld_addr_i`  input  32  byte address of the load in MEM.
- `ld_hit_o`  output  1  load must stall (see Configuration).

## Operation
- Push: the store is accepted when `st_valid_i && st_ready_o` and the store is aligned. Pop: occurs when `mem_valid_o && mem_ready_i`.
- Packing is done at push time and stored per entry as {word addr, wdata, be}:
  - Byte: wdata = `{4{data[7:0]}}`, be = `4'b0001 << addr[1:0]`.
  - Half: wdata = `{2{data[15:0]}}`, be = `4'b0011 << addr[1:0]`.
  - Word: wdata = data, be = `4'b1111`.
- Misaligned stores are rejected: half with `addr[0]=1`, word with `addr[1:0]≠0`, or any store with size 11.
  - On rejection the entry is not written, and `misalign_o` is registered high for the following cycle only.
  - `st_ready_o` is unaffected by the rejection.
- FIFO state: read/write pointers of `$clog2(Depth)` bits wrapping modulo Depth, plus a count of `$clog2(Depth)+1` bits.
- `st_ready_o = (count != Depth)`, a function of the registered count only.
  - When full, a simultaneous pop does not open the slot for a same-cycle push; the push is accepted the cycle after.
- Simultaneous push and pop when not full: the count is unchanged and both pointers advance.
- Entries drain in strict FIFO order. No merging and no reordering.

## Timing
- Push-to-memory latency: an entry accepted at edge N drives `mem_valid_o=1` from edge N onward, i.e. in the cycle after acceptance.
- `mem_valid_o = (count != 0)`. While `mem_valid_o && !mem_ready_i`, the values of `mem_addr_o`, `mem_wdata_o` and `mem_be_o` stay stable.
- When the buffer is empty, `mem_addr_o`, `mem_wdata_o` and `mem_be_o` are driven to 0.
- `empty_o = (count == 0)`, registered.
- Reset values: count=0, pointers=0, `mem_valid_o=0`, `st_ready_o=1`, `empty_o=1`, `misalign_o=0`, `ld_hit_o=0`, all memory data outputs 0.
- Reset asserted mid-operation discards all pending entries on that edge; no beat is presented afterward.
- Full throughput: with `mem_ready_i` held at 1, one store per cycle is sustained indefinitely.

## Configuration
- Macro: `STORE_BUF_FWD_EN`.
- Defined: `ld_hit_o` is combinational. It is 1 iff any valid entry has word address equal to `{ld_addr_i[31:2], 2'b00}`. Otherwise 0.
- Not defined: `ld_hit_o = !empty_o`, a conservative stall whenever stores are pending. The `ld_addr_i` port remains but is unused.

## Test plan
- Pack and reset:
  - sb addr 0x1003 data 0x000000AB -> beat addr 0x1000, wdata 0xABABABAB, be 4'b1000.
  - sh addr 0x2002 data 0x1234 -> wdata 0x12341234, be 4'b1100.
  - sw addr 0x3000 data 0xDEADBEEF -> be 4'b1111.
  - Out of reset -> all outputs at reset values.
- Misalign: sh addr 0x0001 -> not queued, `misalign_o` high exactly one cycle, `empty_o` stays 1. Same for sw addr 0x0002 and size 11.
- Fill and backpressure:
  - `mem_ready_i=0`, push 4 stores -> `st_ready_o=0` after the 4th.
  - 5th `st_valid_i` is held until a pop. With simultaneous pop and push at full, the push is accepted one cycle later.
  - Order is preserved with 8 pushes over wrap-around.
- Stall stability: `mem_ready_i` toggling pseudo-randomly -> head outputs are stable while stalled, and every pushed beat appears exactly once, in order.
- Reset mid-drain: 3 entries pending, assert `rst_i` one cycle -> `mem_valid_o=0`, `empty_o=1` next cycle, no stale beat.
- Forwarding:
  - With `STORE_BUF_FWD_EN`: pending sw 0x4000, `ld_addr_i` 0x4002 -> `ld_hit_o=1`; `ld_addr_i` 0x4004 -> 0.
  - Without the macro: `ld_hit_o=1` whenever non-empty.
